gen1_skp_scheduler: RTL and testbench

GEN1_SKP_SCHEDULER -- requirements
Module: gen1_skp_scheduler

---
 rtl/gen1_skp_scheduler_if.sv | 27 ++
 rtl/gen1_skp_scheduler.sv | 163 ++++++++++++++++
 tb/tb_gen1_skp_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen1_skp_scheduler_if.sv
// Upstream beat stream in, scrambler-facing beat stream out.
// master: beat source and sink; slave: the SKP scheduler.
interface gen1_skp_scheduler_if;
  logic [31:0] data_i;
  logic [3:0]  data_k_i;
  logic        data_valid_i;
  logic        sop_i;
  logic        eop_i;
  logic        data_ready_o;
  logic [31:0] data_o;
  logic [3:0]  data_k_o;
  logic        data_valid_o;

  modport master (
    output data_i, data_k_i, data_valid_i,
    output sop_i, eop_i,
    input  data_ready_o,
    input  data_o, data_k_o, data_valid_o
  );

  modport slave (
    input  data_i, data_k_i, data_valid_i,
    input  sop_i, eop_i,
    output data_ready_o,
    output data_o, data_k_o, data_valid_o
  );
endinterface

// File: rtl/gen1_skp_scheduler.sv
// Gen1 SKP ordered-set scheduler: passes beats, inserts COM+3xSKP between packets.
// Ports: clk_i, rst_ni, enable_i, force_skp_i, pipe_width_i, bus (slave), skp_pending_o.
module gen1_skp_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    force_skp_i,
  input  logic [5:0]              pipe_width_i,
  gen1_skp_scheduler_if.slave     bus,
  output logic                    skp_pending_o
);

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [CNT_W-1:0] INTV =
    CNT_W'(SKP_INTERVAL);

  typedef enum logic {
    S_DATA,
    S_SKP
  } state_t;

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_pkt_q;
  logic             pend_q;
  logic [31:0]      do_q;
  logic [3:0]       ko_q;
  logic             vo_q;

  logic [2:0]       nbytes;
  logic [1:0]       last_idx;
  logic             ready;
  logic             accept;
  logic             go_skp;
  logic             skp_last;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_nx;
  logic             thresh;
  logic [31:0]      skp_data;
  logic [3:0]       skp_k;
  logic [3:0]       sidx;

  // Unknown widths fall back to the full 4-byte beat.
  always_comb begin
    nbytes   = 3'd4;
    last_idx = 2'd0;
    unique case (1'b1)
      pipe_width_i == 6'd8: begin
        nbytes   = 3'd1;
        last_idx = 2'd3;
      end
      pipe_width_i == 6'd16: begin
        nbytes   = 3'd2;
        last_idx = 2'd1;
      end
      default: ;
    endcase
  end

  // Stall upstream only between packets once a set is owed.
  assign ready = (state_q == S_DATA)
               && !(pend_q && !in_pkt_q);
  assign accept = bus.data_valid_i && ready;
  assign go_skp = (state_q == S_DATA)
                && pend_q && !in_pkt_q;
  assign skp_last = (state_q == S_SKP)
                  && (idx_q == last_idx);

  assign cnt_sum = {1'b0, cnt_q}
                 + {{(CNT_W-2){1'b0}}, nbytes};
  assign cnt_inc = cnt_sum[CNT_W] ? '1
                 : cnt_sum[CNT_W-1:0];

  always_comb begin
    cnt_nx = cnt_q;
    if (!enable_i)
      cnt_nx = '0;
    else if (accept)
      cnt_nx = cnt_inc;
  end

  // Uses the post-beat count so the set is owed right after
  // the beat that crosses the interval.
  assign thresh = enable_i && (cnt_nx >= INTV);

  // Symbol n of the ordered set lands in lane n - idx*B.
  always_comb begin
    skp_data = '0;
    skp_k    = '0;
    sidx     = '0;
    for (int l = 0; l < 4; l++) begin
      sidx = ({2'b00, idx_q} * {1'b0, nbytes})
           + 4'(l);
      if (4'(l) < {1'b0, nbytes}) begin
        skp_data[8*l +: 8] =
          (sidx == 4'd0) ? COM : SKP;
        skp_k[l] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_DATA;
      idx_q    <= '0;
      cnt_q    <= '0;
      in_pkt_q <= 1'b0;
      pend_q   <= 1'b0;
      do_q     <= '0;
      ko_q     <= '0;
      vo_q     <= 1'b0;
    end else begin
      do_q <= '0;
      ko_q <= '0;
      vo_q <= 1'b0;
      unique case (state_q)
        S_DATA: begin
          cnt_q <= cnt_nx;
          if (accept) begin
            do_q <= bus.data_i;
            ko_q <= bus.data_k_i;
            vo_q <= 1'b1;
            if (bus.eop_i)
              in_pkt_q <= 1'b0;
            else if (bus.sop_i)
              in_pkt_q <= 1'b1;
          end
          if (go_skp) begin
            state_q <= S_SKP;
            idx_q   <= '0;
            cnt_q   <= '0;
          end else if (force_skp_i || thresh) begin
            pend_q <= 1'b1;
          end
        end
        S_SKP: begin
          do_q  <= skp_data;
          ko_q  <= skp_k;
          vo_q  <= 1'b1;
          idx_q <= idx_q + 2'd1;
          if (skp_last) begin
            state_q <= S_DATA;
            idx_q   <= '0;
            pend_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.data_ready_o = ready;
  assign bus.data_o       = do_q;
  assign bus.data_k_o     = ko_q;
  assign bus.data_valid_o = vo_q;
  assign skp_pending_o    = pend_q;

endmodule

// File: tb/tb_gen1_skp_scheduler.sv
// Bench for gen1_skp_scheduler: reference model plus directed scenarios.
// Compares every cycle at negedge; directed tests pin literal output logs.
module tb_gen1_skp_scheduler;
  localparam int INTV = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic       force_skp_i = 1'b0;
  logic [5:0] pipe_width_i = 6'd32;
  logic       skp_pending_o;

  gen1_skp_scheduler_if bus();

  gen1_skp_scheduler #(
    .SKP_INTERVAL(INTV),
    .CNT_W(16)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .enable_i(enable_i),
    .force_skp_i(force_skp_i),
    .pipe_width_i(pipe_width_i),
    .bus(bus),
    .skp_pending_o(skp_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [35:0] log_q[$];

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // left = ordered-set beats still owed to the output,
  // sym = index of the next ordered-set symbol to send.
  typedef struct packed {
    int          cnt;
    bit          pend;
    bit          inpkt;
    int          left;
    int          sym;
    logic [31:0] d;
    logic [3:0]  k;
    bit          v;
  } mst_t;

  mst_t m = '0;

  function automatic int bpb(logic [5:0] pw);
    if (pw == 6'd8) return 1;
    if (pw == 6'd16) return 2;
    return 4;
  endfunction

  function automatic bit m_rdy(mst_t s);
    return s.left == 0 && !(s.pend && !s.inpkt);
  endfunction

  function automatic mst_t m_next(
    mst_t s, logic [5:0] pw, logic en, logic frc,
    logic vld, logic sop, logic eop,
    logic [31:0] din, logic [3:0] kin);
    mst_t n = s;
    int b = bpb(pw);
    logic [31:0] d = '0;
    logic [3:0] k = '0;
    n.v = 1'b0;
    if (s.left > 0) begin
      for (int l = 0; l < b; l++) begin
        d[8*l +: 8] = (s.sym + l == 0) ? 8'hBC : 8'h1C;
        k[l] = 1'b1;
      end
      n.v = 1'b1;
      n.sym = s.sym + b;
      n.left = s.left - 1;
      if (n.left == 0) n.pend = 1'b0;
    end else begin
      if (!en) n.cnt = 0;
      if (vld && m_rdy(s)) begin
        d = din;
        k = kin;
        n.v = 1'b1;
        if (en)
          n.cnt = (s.cnt + b > 65535) ? 65535 : s.cnt + b;
        if (eop) n.inpkt = 1'b0;
        else if (sop) n.inpkt = 1'b1;
      end
      if (s.pend && !s.inpkt) begin
        n.left = 4 / b;
        n.sym = 0;
        n.cnt = 0;
      end else if (frc || (en && n.cnt >= INTV)) begin
        n.pend = 1'b1;
      end
    end
    n.d = d;
    n.k = k;
    return n;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      m <= '0;
    else
      m <= m_next(m, pipe_width_i, enable_i,
                  force_skp_i, bus.data_valid_i,
                  bus.sop_i, bus.eop_i,
                  bus.data_i, bus.data_k_i);
  end

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("ready", 64'(bus.data_ready_o), 64'(m_rdy(m)));
      chk("valid", 64'(bus.data_valid_o), 64'(m.v));
      chk("data", 64'(bus.data_o), 64'(m.d));
      chk("k", 64'(bus.data_k_o), 64'(m.k));
      chk("pending", 64'(skp_pending_o), 64'(m.pend));
      if (rst_ni && bus.data_valid_o)
        log_q.push_back({bus.data_k_o, bus.data_o});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    bus.data_valid_i = 1'b0;
    bus.sop_i = 1'b0;
    bus.eop_i = 1'b0;
    bus.data_i = '0;
    bus.data_k_i = '0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    idle_in();
    force_skp_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    log_q.delete();
    #2 rst_ni = 1'b1;
  endtask

  task automatic stream(int n, logic [31:0] base,
                        output int lows);
    int cur = 0;
    logic rdy;
    lows = 0;
    repeat (n) begin
      @(negedge clk_i);
      #1;
      bus.data_valid_i = 1'b1;
      bus.sop_i = 1'b1;
      bus.eop_i = 1'b1;
      bus.data_i = base + 32'(cur);
      bus.data_k_i = '0;
      rdy = bus.data_ready_o;
      if (!rdy) lows++;
      @(posedge clk_i);
      if (rdy) cur++;
    end
    @(negedge clk_i);
    #1 idle_in();
  endtask

  task automatic send_pkt(int n, logic [31:0] base);
    int i = 0;
    int guard = 0;
    logic rdy;
    while (i < n && guard < 1000) begin
      @(negedge clk_i);
      #1;
      bus.data_valid_i = 1'b1;
      bus.sop_i = (i == 0);
      bus.eop_i = (i == n - 1);
      bus.data_i = base + 32'(i);
      bus.data_k_i = '0;
      rdy = bus.data_ready_o;
      @(posedge clk_i);
      if (rdy) i++;
      guard++;
    end
    @(negedge clk_i);
    #1 idle_in();
    chk("pkt_beats_sent", 64'(i), 64'(n));
  endtask

  task automatic pulse_force();
    @(negedge clk_i);
    #1 force_skp_i = 1'b1;
    @(negedge clk_i);
    #1 force_skp_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int lows;
    int nk;
    idle_in();
    idle(2);
    chk_en = 1'b1;

    // reset values
    #1;
    chk("rst_data", 64'(bus.data_o), 64'h0);
    chk("rst_valid", 64'(bus.data_valid_o), 64'h0);
    chk("rst_ready", 64'(bus.data_ready_o), 64'h1);
    chk("rst_pend", 64'(skp_pending_o), 64'h0);

    // 32-bit, interval 8, back-to-back single-beat packets
    pipe_width_i = 6'd32;
    enable_i = 1'b1;
    do_reset();
    stream(6, 32'hA000_0000, lows);
    idle(6);
    chk("w32_ready_low", 64'(lows), 64'd2);
    chk("w32_log_n", 64'(log_q.size()), 64'd6);
    if (log_q.size() >= 6) begin
      chk("w32_b0", 64'(log_q[0]), 64'h0_A000_0000);
      chk("w32_b1", 64'(log_q[1]), 64'h0_A000_0001);
      chk("w32_skp", 64'(log_q[2]), 64'hF_1C1C_1CBC);
      chk("w32_b2", 64'(log_q[3]), 64'h0_A000_0002);
      chk("w32_b3", 64'(log_q[4]), 64'h0_A000_0003);
      chk("w32_skp2", 64'(log_q[5]), 64'hF_1C1C_1CBC);
    end

    // 8-bit forced set while idle
    pipe_width_i = 6'd8;
    enable_i = 1'b0;
    do_reset();
    pulse_force();
    idle(8);
    chk("w8_log_n", 64'(log_q.size()), 64'd4);
    if (log_q.size() >= 4) begin
      chk("w8_com", 64'(log_q[0]), 64'h1_0000_00BC);
      chk("w8_s1", 64'(log_q[1]), 64'h1_0000_001C);
      chk("w8_s2", 64'(log_q[2]), 64'h1_0000_001C);
      chk("w8_s3", 64'(log_q[3]), 64'h1_0000_001C);
    end

    // 16-bit, threshold crossed inside a 10-beat packet
    pipe_width_i = 6'd16;
    enable_i = 1'b1;
    do_reset();
    send_pkt(10, 32'hB000_0000);
    idle(6);
    chk("w16_log_n", 64'(log_q.size()), 64'd12);
    if (log_q.size() >= 12) begin
      for (int i = 0; i < 10; i++)
        chk("w16_pkt", 64'(log_q[i]),
            {28'h0, 4'h0, 32'hB000_0000 + 32'(i)});
      chk("w16_skp0", 64'(log_q[10]), 64'h3_0000_1CBC);
      chk("w16_skp1", 64'(log_q[11]), 64'h3_0000_1C1C);
    end

    // enable low for 5000 beats, then one forced set
    pipe_width_i = 6'd32;
    enable_i = 1'b0;
    do_reset();
    stream(5000, 32'hC000_0000, lows);
    idle(3);
    nk = 0;
    foreach (log_q[i])
      if (log_q[i][35:32] != 4'h0) nk++;
    chk("dis_no_skp", 64'(nk), 64'd0);
    chk("dis_beats", 64'(log_q.size()), 64'd5000);
    chk("dis_ready_low", 64'(lows), 64'd0);
    log_q.delete();
    pulse_force();
    idle(6);
    chk("dis_force_n", 64'(log_q.size()), 64'd1);
    if (log_q.size() >= 1)
      chk("dis_force_skp", 64'(log_q[0]), 64'hF_1C1C_1CBC);

    // reset during the second 16-bit SKP beat
    pipe_width_i = 6'd16;
    enable_i = 1'b0;
    do_reset();
    pulse_force();
    idle(2);
    #1;
    chk("mid_beat0", 64'(bus.data_o), 64'h0000_1CBC);
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_rst_data", 64'(bus.data_o), 64'h0);
    chk("mid_rst_valid", 64'(bus.data_valid_o), 64'h0);
    chk("mid_rst_k", 64'(bus.data_k_o), 64'h0);
    chk("mid_rst_pend", 64'(skp_pending_o), 64'h0);
    chk("mid_rst_ready", 64'(bus.data_ready_o), 64'h1);
    @(negedge clk_i);
    log_q.delete();
    #2 rst_ni = 1'b1;
    send_pkt(1, 32'hD000_0001);
    idle(5);
    chk("mid_log_n", 64'(log_q.size()), 64'd1);
    if (log_q.size() >= 1)
      chk("mid_first", 64'(log_q[0]), 64'h0_D000_0001);
    chk("mid_pend", 64'(skp_pending_o), 64'h0);

    // force held across the whole set: only one set
    pipe_width_i = 6'd8;
    enable_i = 1'b0;
    do_reset();
    @(negedge clk_i);
    #1 force_skp_i = 1'b1;
    repeat (6) @(negedge clk_i);
    #1 force_skp_i = 1'b0;
    idle(10);
    chk("hold_log_n", 64'(log_q.size()), 64'd4);
    if (log_q.size() >= 4) begin
      chk("hold_com", 64'(log_q[0]), 64'h1_0000_00BC);
      chk("hold_s3", 64'(log_q[3]), 64'h1_0000_001C);
    end
    chk("hold_pend", 64'(skp_pending_o), 64'h0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
